uart_tx_arbiter: RTL and testbench

Shares a single `uart_core` transmit path among `NUM_REQ` byte-producing requesters. The block is the sole bus master on the UART slot interface. After reset it programs the control register. It then arbitrates pending bytes round-robin, polls the status register for Tx FIFO space, and writes each winning byte to the write register. It also applies runtime control-register updates with priority over data traffic.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: sole master of the uart_core slot bus. Writes the control
// word after reset, then serves control-word updates ahead of round-robin
// byte requests. Each byte needs a status poll showing Tx FIFO space before
// it is written to the data register.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter logic [15:0] CTRL_INIT = 16'h0145
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  input  logic                 cfg_wr,
  input  logic [15:0]          cfg_data,
  output logic                 cfg_ack,
  output logic                 busy,
  output logic                 cs,
  output logic                 read,
  output logic                 write,
  output logic [4:0]           reg_addr,
  output logic [31:0]          wr_data,
  input  logic [31:0]          rd_data
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_POLL  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CFG   = 3'd5;

  localparam logic [4:0] A_CTRL   = 5'd0;
  localparam logic [4:0] A_STATUS = 5'd1;
  localparam logic [4:0] A_WDATA  = 5'd3;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] win_q, win_d;
  logic [7:0]    byte_q, byte_d;
  logic [15:0]   cfg_q, cfg_d;

  logic [7:0]    req_byte [NUM_REQ];
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          tx_full;

  // Only the tx_full status bit matters to this block.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{rd_data[31:5], rd_data[3:0]};
  assign tx_full        = rd_data[4];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[g*8 +: 8];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(last_grant_q) + 32'd1 + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and latch selection; arbitration is only consulted in IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    byte_d       = byte_q;
    cfg_d        = cfg_q;
    case (state_q)
      S_BOOT: state_d = S_INIT;
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (cfg_wr) begin
          cfg_d   = cfg_data;
          state_d = S_CFG;
        end else if (found) begin
          win_d   = pick;
          byte_d  = req_byte[pick];
          state_d = S_POLL;
        end
      end
      S_POLL:  state_d = tx_full ? S_POLL : S_WRITE;
      S_WRITE: begin
        last_grant_d = win_q;
        state_d      = S_IDLE;
      end
      S_CFG:   state_d = S_IDLE;
      default: state_d = S_BOOT;
    endcase
  end

  // State and latched transaction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      last_grant_q <= IW'(NUM_REQ - 1);
      win_q        <= '0;
      byte_q       <= '0;
      cfg_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      byte_q       <= byte_d;
      cfg_q        <= cfg_d;
    end
  end

  // Slot bus and handshake outputs decoded from the state register.
  always_comb begin
    cs       = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    reg_addr = '0;
    wr_data  = '0;
    ack      = '0;
    cfg_ack  = 1'b0;
    case (state_q)
      S_INIT: begin
        cs       = 1'b1;
        write    = 1'b1;
        reg_addr = A_CTRL;
        wr_data  = {16'h0, CTRL_INIT};
      end
      S_POLL: begin
        cs       = 1'b1;
        read     = 1'b1;
        reg_addr = A_STATUS;
      end
      S_WRITE: begin
        cs         = 1'b1;
        write      = 1'b1;
        reg_addr   = A_WDATA;
        wr_data    = {24'h0, byte_q};
        ack[win_q] = 1'b1;
      end
      S_CFG: begin
        cs       = 1'b1;
        write    = 1'b1;
        reg_addr = A_CTRL;
        wr_data  = {16'h0, cfg_q};
        cfg_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  // BOOT counts as busy, but busy must read 0 while reset is held.
  assign busy = !reset && (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter with a combinational
// status-register model whose tx_full bit is driven from the stimulus table.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        cfg_wr;
  logic [15:0] cfg_data;
  logic        cfg_ack;
  logic        busy;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx_full;

  int tests;
  int fails;
  int addr2_cnt;

  uart_tx_arbiter #(.NUM_REQ(4), .CTRL_INIT(16'h0145)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .cfg_wr(cfg_wr), .cfg_data(cfg_data), .cfg_ack(cfg_ack), .busy(busy),
    .cs(cs), .read(read), .write(write), .reg_addr(reg_addr),
    .wr_data(wr_data), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status register: bit 4 tx_full, bit 3 set to show other bits are ignored.
  always_comb begin
    rd_data = 32'h0;
    if (reg_addr == 5'd1) rd_data = {27'h0, tx_full, 4'b1000};
  end

  always @(negedge clk) if (cs && reg_addr == 5'd2) addr2_cnt++;

  // Output bundle: {cs, read, write, reg_addr, wr_data, ack, cfg_ack, busy}
  function automatic logic [45:0] actual();
    return {cs, read, write, reg_addr, wr_data, ack, cfg_ack, busy};
  endfunction

  function automatic logic [45:0] o_idle();
    return 46'h0;
  endfunction
  function automatic logic [45:0] o_init();
    return {1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0145, 4'b0000, 1'b0, 1'b1};
  endfunction
  function automatic logic [45:0] o_poll();
    return {1'b1, 1'b1, 1'b0, 5'd1, 32'h0, 4'b0000, 1'b0, 1'b1};
  endfunction
  function automatic logic [45:0] o_wr(input logic [7:0] b, input logic [3:0] k);
    return {1'b1, 1'b0, 1'b1, 5'd3, {24'h0, b}, k, 1'b0, 1'b1};
  endfunction
  function automatic logic [45:0] o_cfg(input logic [15:0] w);
    return {1'b1, 1'b0, 1'b1, 5'd0, {16'h0, w}, 4'b0000, 1'b1, 1'b1};
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [31:0] rdat;
    logic        cfg;
    logic [15:0] cdat;
    logic        full;
    logic [45:0] exp;
  } vec_t;

  localparam int NV = 33;
  vec_t tv [NV];

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d,
                              input logic c, input logic [15:0] cd,
                              input logic f, input logic [45:0] e);
    vec_t v;
    v.req = r; v.rdat = d; v.cfg = c; v.cdat = cd; v.full = f; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [45:0] act, input logic [45:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] RR = 32'h4433_2211;

  initial begin
    tests = 0; fails = 0; addr2_cnt = 0;
    reset = 1'b1; req = 4'b0; req_data = 32'h0;
    cfg_wr = 1'b0; cfg_data = 16'h0; tx_full = 1'b0;

    // boot and round-robin with all four held
    tv[0]  = mk(4'b0000, 32'h0, 1'b0, 16'h0, 1'b0, o_init());
    tv[1]  = mk(4'b0000, 32'h0, 1'b0, 16'h0, 1'b0, o_idle());
    tv[2]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_poll());
    tv[3]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_wr(8'h11, 4'b0001));
    tv[4]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_idle());
    tv[5]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_poll());
    tv[6]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_wr(8'h22, 4'b0010));
    tv[7]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_idle());
    tv[8]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_poll());
    tv[9]  = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_wr(8'h33, 4'b0100));
    tv[10] = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_idle());
    tv[11] = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_poll());
    tv[12] = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_wr(8'h44, 4'b1000));
    tv[13] = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_idle());
    tv[14] = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_poll());
    tv[15] = mk(4'b1111, RR, 1'b0, 16'h0, 1'b0, o_wr(8'h11, 4'b0001));
    tv[16] = mk(4'b0000, RR, 1'b0, 16'h0, 1'b0, o_idle());
    // single byte from requester 2
    tv[17] = mk(4'b0100, 32'h00A5_0000, 1'b0, 16'h0, 1'b0, o_poll());
    tv[18] = mk(4'b0100, 32'h00A5_0000, 1'b0, 16'h0, 1'b0, o_wr(8'hA5, 4'b0100));
    tv[19] = mk(4'b0000, 32'h0, 1'b0, 16'h0, 1'b0, o_idle());
    // back-pressure: five extra polls while tx_full
    tv[20] = mk(4'b0010, 32'h0000_5C00, 1'b0, 16'h0, 1'b1, o_poll());
    tv[21] = mk(4'b0010, 32'h0000_5C00, 1'b0, 16'h0, 1'b1, o_poll());
    tv[22] = mk(4'b0010, 32'h0000_5C00, 1'b0, 16'h0, 1'b1, o_poll());
    tv[23] = mk(4'b0010, 32'h0000_5C00, 1'b0, 16'h0, 1'b1, o_poll());
    tv[24] = mk(4'b0010, 32'h0000_5C00, 1'b0, 16'h0, 1'b1, o_poll());
    tv[25] = mk(4'b0010, 32'h0000_5C00, 1'b0, 16'h0, 1'b1, o_poll());
    tv[26] = mk(4'b0010, 32'h0000_5C00, 1'b0, 16'h0, 1'b0, o_wr(8'h5C, 4'b0010));
    tv[27] = mk(4'b0000, 32'h0, 1'b0, 16'h0, 1'b0, o_idle());
    // config beats a simultaneous request
    tv[28] = mk(4'b0010, 32'h0000_7700, 1'b1, 16'h80A3, 1'b0, o_cfg(16'h80A3));
    tv[29] = mk(4'b0010, 32'h0000_7700, 1'b0, 16'h0, 1'b0, o_idle());
    tv[30] = mk(4'b0010, 32'h0000_7700, 1'b0, 16'h0, 1'b0, o_poll());
    tv[31] = mk(4'b0010, 32'h0000_7700, 1'b0, 16'h0, 1'b0, o_wr(8'h77, 4'b0010));
    tv[32] = mk(4'b0000, 32'h0, 1'b0, 16'h0, 1'b0, o_idle());

    @(negedge clk);
    @(negedge clk);
    check("reset_values", actual(), o_idle());

    reset = 1'b0;
    #1;
    check("boot_no_access", {actual()[45:2], 2'b00}, 46'h0);

    for (int i = 0; i < NV; i++) begin
      req = tv[i].req; req_data = tv[i].rdat;
      cfg_wr = tv[i].cfg; cfg_data = tv[i].cdat; tx_full = tv[i].full;
      step();
      check($sformatf("vec%0d", i), actual(), tv[i].exp);
    end

    // Reset while polling: outputs drop at once, byte discarded, boot replays.
    req = 4'b0001; req_data = 32'h0000_0099; tx_full = 1'b1;
    step();
    check("midrst_poll", actual(), o_poll());
    reset = 1'b1;
    #1;
    check("midrst_asserted", actual(), o_idle());
    step();
    check("midrst_held", actual(), o_idle());
    reset = 1'b0; req = 4'b0000; tx_full = 1'b0;
    #1;
    check("midrst_boot", {actual()[45:2], 2'b00}, 46'h0);
    step();
    check("midrst_init", actual(), o_init());
    step();
    check("midrst_idle", actual(), o_idle());
    // last_grant restored to 3, so requester 1 beats requester 3.
    req = 4'b1010; req_data = 32'hD400_B200;
    step();
    check("postrst_poll", actual(), o_poll());
    step();
    check("postrst_write", actual(), o_wr(8'hB2, 4'b0010));
    req = 4'b0000;
    step();
    check("postrst_idle", actual(), o_idle());

    check("no_addr2_access", 46'(addr2_cnt), 46'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
